window_feeder: RTL and testbench

Streaming window generator for the convolution datapath. It accepts a raster-order 8-bit pixel stream and holds K-1 line buffers. For every pixel that completes a KxK neighbourhood, it presents the packed window, plus a stored kernel vector, in exactly the byte layout the multiply-adder tree consumes. It is the producer side of the window/kernel interface, one instance per multiply-adder tree.

---
 rtl/window_feeder.sv | 106 ++++++++++
 tb/tb_window_feeder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_feeder.sv
// Streaming KxK window generator: K-1 line buffers feed a window register whose packed
// layout (row-major, byte r*K+c) matches the multiply-adder tree input; kernel is shift-loaded.
module window_feeder #(
  parameter int unsigned IMG_WIDTH   = 28,
  parameter int unsigned IMG_HEIGHT  = 28,
  parameter int unsigned KERNEL_SIZE = 3
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      pixel_valid,
  input  logic [7:0]                                pixel_in,
  input  logic                                      frame_start,
  input  logic                                      kernel_wr_en,
  input  logic [7:0]                                kernel_wr_data,
  output logic [8*KERNEL_SIZE*KERNEL_SIZE-1:0]      window_out,
  output logic [8*KERNEL_SIZE*KERNEL_SIZE-1:0]      kernel_out,
  output logic                                      window_valid,
  output logic                                      frame_done,
  output logic [15:0]                               out_row,
  output logic [15:0]                               out_col
);
  localparam int          K        = int'(KERNEL_SIZE);
  localparam int          N        = K * K;
  localparam int          CW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [15:0] KM1      = 16'(K - 1);
  localparam logic [15:0] COL_LAST = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] ROW_LAST = 16'(IMG_HEIGHT - 1);

  logic [15:0]    row_q, col_q;
  logic [15:0]    cur_row, cur_col;
  logic [CW-1:0]  col_idx;
  logic           emit;
  logic [7:0]     line_q [K-1][IMG_WIDTH];
  logic [7:0]     col_vec [K];
  logic [8*N-1:0] win_d;

  // frame_start relabels the accepted pixel as (0,0) regardless of the counters
  always_comb begin
    cur_row = frame_start ? '0 : row_q;
    cur_col = frame_start ? '0 : col_q;
    col_idx = cur_col[CW-1:0];
    emit    = pixel_valid && (cur_row >= KM1) && (cur_col >= KM1);
  end

  // line_q[0] holds the oldest row; the incoming pixel is the bottom of the column
  always_comb begin
    for (int j = 0; j < K - 1; j++) begin
      col_vec[j] = line_q[j][col_idx];
    end
    col_vec[K-1] = pixel_in;
  end

  always_comb begin
    win_d = window_out;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_d[8*(r*K+c) +: 8] = window_out[8*(r*K+c+1) +: 8];
      end
      win_d[8*(r*K+K-1) +: 8] = col_vec[r];
    end
  end

  // Line buffers are deliberately not reset; emission gating hides stale contents
  always_ff @(posedge clock) begin
    if (pixel_valid) begin
      for (int j = 0; j < K - 2; j++) begin
        line_q[j][col_idx] <= line_q[j+1][col_idx];
      end
      line_q[K-2][col_idx] <= pixel_in;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_q        <= '0;
      col_q        <= '0;
      window_out   <= '0;
      kernel_out   <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      out_row      <= '0;
      out_col      <= '0;
    end else begin
      window_valid <= emit;
      frame_done   <= emit && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
      if (emit) begin
        out_row <= cur_row - KM1;
        out_col <= cur_col - KM1;
      end
      if (pixel_valid) begin
        window_out <= win_d;
        if (cur_col == COL_LAST) begin
          col_q <= '0;
          row_q <= (cur_row == ROW_LAST) ? '0 : cur_row + 16'd1;
        end else begin
          col_q <= cur_col + 16'd1;
          row_q <= cur_row;
        end
      end
      if (kernel_wr_en) begin
        kernel_out <= {kernel_wr_data, kernel_out[8*N-1:8]};
      end
    end
  end

endmodule

// File: tb/tb_window_feeder.sv
// Scoreboard bench for window_feeder at 5x4 image, 3x3 kernel: a 2-D image model predicts
// every window when a pixel is driven; DUT outputs are popped and compared one cycle later.
module tb_window_feeder;
  localparam int W = 5;
  localparam int H = 4;
  localparam int K = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [7:0]  pixel_in = '0;
  logic        frame_start = 1'b0;
  logic        kernel_wr_en = 1'b0;
  logic [7:0]  kernel_wr_data = '0;
  logic [71:0] window_out, kernel_out;
  logic        window_valid, frame_done;
  logic [15:0] out_row, out_col;

  window_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL_SIZE(K)) dut (
    .clock          (clock),
    .reset          (reset),
    .pixel_valid    (pixel_valid),
    .pixel_in       (pixel_in),
    .frame_start    (frame_start),
    .kernel_wr_en   (kernel_wr_en),
    .kernel_wr_data (kernel_wr_data),
    .window_out     (window_out),
    .kernel_out     (kernel_out),
    .window_valid   (window_valid),
    .frame_done     (frame_done),
    .out_row        (out_row),
    .out_col        (out_col)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [71:0] win;
    logic [15:0] row;
    logic [15:0] col;
    logic        done;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         m_row = 0;
  int         m_col = 0;
  logic [7:0] img [H][W];

  localparam logic [71:0] FIRST_WIN = 72'h0c0b0a070605020100;
  localparam logic [71:0] LAST_WIN  = 72'h1312110e0d0c090807;

  function automatic exp_t actual();
    return {window_out, out_row, out_col, frame_done};
  endfunction

  function automatic void model_reset();
    m_row = 0;
    m_col = 0;
    sb.delete();
  endfunction

  function automatic void model_accept(logic [7:0] pix, logic fs);
    exp_t e;
    if (fs) begin
      m_row = 0;
      m_col = 0;
    end
    img[m_row][m_col] = pix;
    if (m_row >= K - 1 && m_col >= K - 1) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          e.win[8*(r*K+c) +: 8] = img[m_row-K+1+r][m_col-K+1+c];
      e.row  = 16'(m_row - K + 1);
      e.col  = 16'(m_col - K + 1);
      e.done = (m_row == H - 1) && (m_col == W - 1);
      sb.push_back(e);
    end
    m_col++;
    if (m_col == W) begin
      m_col = 0;
      m_row = (m_row == H - 1) ? 0 : m_row + 1;
    end
  endfunction

  // Drive one cycle of pixel stimulus, record expectations, then sample 1 time unit past the edge
  task automatic cycle(input logic v, input logic [7:0] pix, input logic fs);
    pixel_valid = v;
    pixel_in    = pix;
    frame_start = fs;
    if (v) model_accept(pix, fs);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pixel_valid = 1'b1;
    pixel_in = 8'h55;
    frame_start = 1'b1;
    kernel_wr_en = 1'b1;
    kernel_wr_data = 8'haa;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      n_checks++;
      if ({actual(), kernel_out, window_valid} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold got %h kern %h valid %b need all zero", actual(), kernel_out,
                 window_valid);
      end
    end
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    kernel_wr_en = 1'b0;
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    n_checks++;
    if ({actual(), kernel_out, window_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_release got %h kern %h valid %b need all zero", actual(), kernel_out,
               window_valid);
    end
  endtask

  task automatic test_kernel_load();
    logic [71:0] exp_k = '0;
    for (int i = 1; i <= 9; i++) begin
      kernel_wr_en = 1'b1;
      kernel_wr_data = 8'(i);
      @(posedge clock);
      #1;
      exp_k = {8'(i), exp_k[71:8]};
      n_checks++;
      if (kernel_out !== exp_k) begin
        n_fail++;
        $display("FAIL kernel_step%0d got %h need %h", i, kernel_out, exp_k);
      end
    end
    kernel_wr_en = 1'b0;
    kernel_wr_data = 8'hff;
    @(posedge clock);
    #1;
    n_checks++;
    if (kernel_out !== 72'h090807060504030201) begin
      n_fail++;
      $display("FAIL kernel_final got %h need %h", kernel_out, 72'h090807060504030201);
    end
  endtask

  task automatic test_continuous();
    exp_t e;
    int   nwin = 0;
    exp_t first_act = '0;
    exp_t last_act = '0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 8'(i), i == 0);
      n_checks++;
      if (window_valid) begin
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL cont_extra got %h need no window", actual());
        end else begin
          e = sb.pop_front();
          nwin++;
          if (nwin == 1) first_act = actual();
          last_act = actual();
          if (actual() !== e) begin
            n_fail++;
            $display("FAIL cont_window got %h need %h", actual(), e);
          end
        end
      end else if (sb.size() != 0 || frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL cont_missing got valid=0 done=%b need window %h", frame_done, sb[0]);
        sb.delete();
      end
    end
    cycle(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (nwin != 6 || window_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_count got %0d windows valid=%b need 6 valid=0", nwin, window_valid);
    end
    n_checks++;
    if (first_act !== {FIRST_WIN, 16'd0, 16'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL cont_first got %h need %h", first_act, {FIRST_WIN, 16'd0, 16'd0, 1'b0});
    end
    n_checks++;
    if (last_act !== {LAST_WIN, 16'd1, 16'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL cont_last got %h need %h", last_act, {LAST_WIN, 16'd1, 16'd2, 1'b1});
    end
  endtask

  task automatic test_bubbles();
    exp_t e;
    int   nwin = 0;
    int   acc = 0;
    int   guard = 0;
    logic v;
    while (acc < 20 && guard < 200) begin
      guard++;
      v = ($urandom_range(0, 2) != 0);
      cycle(v, v ? 8'(acc) : 8'hee, v && acc == 0);
      n_checks++;
      if (!v && window_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL bub_after_stall got valid=%b need 0", window_valid);
      end else if (window_valid) begin
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL bub_extra got %h need no window", actual());
        end else begin
          e = sb.pop_front();
          nwin++;
          if (actual() !== e) begin
            n_fail++;
            $display("FAIL bub_window got %h need %h", actual(), e);
          end
        end
      end else if (sb.size() != 0) begin
        n_fail++;
        $display("FAIL bub_missing got valid=0 need window %h", sb[0]);
        sb.delete();
      end
      if (v) acc++;
    end
    cycle(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (acc != 20 || nwin != 6) begin
      n_fail++;
      $display("FAIL bub_count got %0d pixels %0d windows need 20 and 6", acc, nwin);
    end
  endtask

  task automatic test_restart();
    exp_t e;
    int   nwin = 0;
    for (int i = 0; i < 27; i++) begin
      if (i < 7) cycle(1'b1, 8'(200 + i), i == 0);
      else cycle(1'b1, 8'(100 + i - 7), i == 7);
      n_checks++;
      if (window_valid) begin
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rst_frame_extra got %h need no window", actual());
        end else begin
          e = sb.pop_front();
          nwin++;
          if (actual() !== e) begin
            n_fail++;
            $display("FAIL restart_window got %h need %h", actual(), e);
          end
        end
      end else if (sb.size() != 0) begin
        n_fail++;
        $display("FAIL restart_missing got valid=0 need window %h", sb[0]);
        sb.delete();
      end
    end
    cycle(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (nwin != 6) begin
      n_fail++;
      $display("FAIL restart_count got %0d need 6", nwin);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   nwin = 0;
    for (int i = 0; i < 34; i++) begin
      if (i == 14) begin
        reset = 1'b0;
        pixel_valid = 1'b0;
        model_reset();
        #2;
        n_checks++;
        if ({actual(), kernel_out, window_valid} !== '0) begin
          n_fail++;
          $display("FAIL midreset_clear got %h kern %h valid %b need all zero", actual(),
                   kernel_out, window_valid);
        end
        @(posedge clock);
        #3;
        reset = 1'b1;
        @(posedge clock);
        #1;
      end
      cycle(1'b1, 8'((i < 14) ? i : i - 14), i == 0);
      n_checks++;
      if (window_valid) begin
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL midreset_extra got %h need no window", actual());
        end else begin
          e = sb.pop_front();
          nwin++;
          if (actual() !== e) begin
            n_fail++;
            $display("FAIL midreset_window got %h need %h", actual(), e);
          end
        end
      end else if (sb.size() != 0) begin
        n_fail++;
        $display("FAIL midreset_missing got valid=0 need window %h", sb[0]);
        sb.delete();
      end
    end
    cycle(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (nwin != 8) begin
      n_fail++;
      $display("FAIL midreset_count got %0d need 8 (2 before, 6 after)", nwin);
    end
  endtask

  initial begin
    test_reset();
    test_kernel_load();
    test_continuous();
    test_bubbles();
    test_restart();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
